mac_result_collector: RTL and testbench
=======================================

Name: mac_result_collector

Overview:
- Downstream stage of the MAC datapath. Tracks every operation issued into the MAC pipeline and captures the 128-bit result and per-operation FP exception flags exactly MAC_LAT cycles after issue.
- Buffers results in a small FIFO and presents them on a valid/ready port to the tile writeback.
- Uses issue-side credits so the MAC, which cannot stall, never delivers a result with no FIFO slot free.

Parameters:
- MAC_LAT, 2, cycles from issue to valid mac_out_i/flags (MAC pipeline depth), >=1
- DEPTH, 4, FIFO entries, power of two, >= MAC_LAT
- TAG_W, 4, width of the user tag carried with each operation

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  operation presented to MAC this cycle
- issue_ready_o  out  1  credit available; issue accepted when valid&ready
- issue_mode_i  in  3  MAC mode code (000..110)
- issue_tag_i  in  TAG_W  tag returned with result
- mac_out_i  in  128  MAC result
- mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i  in  1 each  MAC exception flags, same cycle as mac_out_i
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts
- out_data_o  out  128  result
- out_tag_o  out  TAG_W  tag
- out_mode_o  out  3  mode of result
- out_flags_o  out  4  {NV,OF,UF,NX} of this result, masked
- out_err_o  out  1  mode was 111 (illegal)
- sticky_flags_o  out  4  OR of all popped out_flags_o since last clear
- flags_clr_i  in  1  clear sticky flags
- occupancy_o  out  $clog2(DEPTH)+1  FIFO entries held

Behaviour:
- Reset (synchronous): delay line, FIFO and pointers emptied. Outputs return to: out_valid_o=0, out_data_o=0, out_tag_o=0, out_mode_o=0, out_flags_o=0, out_err_o=0, sticky_flags_o=0, occupancy_o=0, issue_ready_o=1.
- Reset mid-operation: in-flight and buffered results are discarded. MAC outputs arriving afterwards are ignored, because the delay-line valids are cleared.
- Issue accept: accept = issue_valid_i & issue_ready_o. Push {valid, mode, tag} into a MAC_LAT-deep shift register.
- Capture: at the tail (cycle t+MAC_LAT for issue at t), sample mac_out_i and the four flags. Write {data, tag, mode, flags, err} into the FIFO.
- Flag masking: flags are kept only for modes 000/001/010. They are zeroed for 011/100/101/110 (integer/adjacent-add). err=1 only for mode 111; the data is still captured.
- Credits: inflight = number of valid stages in the delay line. issue_ready_o = (inflight + occupancy) < DEPTH, evaluated on registered counts.
  - A pop in cycle c frees credit from c+1.
  - A capture and a pop in the same cycle leave occupancy unchanged.
- Latency without bypass: the FIFO write occurs at t+MAC_LAT, giving out_valid_o=1 at t+MAC_LAT+1 at the earliest.
- Output: out_* are driven from the FIFO head (registered storage). They hold stable while out_valid_o & ~out_ready_i. Pop when out_valid_o & out_ready_i.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full = occupancy==DEPTH, which credits guarantee is never exceeded. A capture while full is a design bug, flagged by an assertion.
- Sticky flags: sticky <= (flags_clr_i ? 0 : sticky) | (pop ? out_flags_o : 0). A pop in the same cycle as a clear is therefore retained.
- Throughput: one issue and one pop per cycle sustained when out_ready_i=1.

Optional Feature:
- Macro MAC_RESULT_BYPASS_EN.
- With it: when the FIFO is empty and a capture occurs, the tail entry is driven directly on out_* with out_valid_o=1 in cycle t+MAC_LAT.
  - If out_ready_i=1 that cycle, the entry is consumed and not written.
  - Otherwise it is written to the FIFO and shown from the FIFO in following cycles with no glitch in values.
- Without it: behaviour is strictly registered as above, with latency MAC_LAT+1.

Decomposition:
- Shared package mac_pkg holds:
  - mode localparams: MODE_FP16, MODE_FP16_MIX, MODE_FP32, MODE_INT4, MODE_ADJ16, MODE_INT4_MIX, MODE_INT8_MIX, MODE_ILLEGAL=3'b111
  - typedef mac_flags_t: packed {nv,of,uf,nx}
  - typedef mac_result_t: packed {data, tag, mode, flags, err}
- One sub-module: mac_result_fifo, a generic synchronous FIFO of mac_result_t with push/pop/occupancy. The delay line and credit logic stay in the top.

Test Plan:
- Single FP32 issue (mode 010, tag 3) at cycle 10; mac_out_i=128'h1234 with OF=1 at cycle 12 -> out_valid_o at cycle 13, data 128'h1234, tag 3, out_flags_o=4'b0100; after pop, sticky=4'b0100.
- Mode 101 issue with mac NX=1 -> out_flags_o=0, sticky unchanged. Mode 111 issue -> out_err_o=1.
- Back-to-back issues with out_ready_i=0, DEPTH=4 -> exactly 4 accepted, then issue_ready_o=0. Raise out_ready_i -> issue_ready_o=1 one cycle after the first pop; tags emerge in order 0,1,2,3.
- Streaming 16 issues with out_ready_i=1 -> one result per cycle, pointers wrap, tags 0..15 in order, occupancy never exceeds 1 (0 with bypass).
- rst asserted with 2 in flight and 2 buffered -> next cycle out_valid_o=0, occupancy_o=0, issue_ready_o=1; stale mac_out_i is never output.
- flags_clr_i asserted in the same cycle as a pop carrying NV=1 -> sticky_flags_o=4'b1000 next cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path.
// Holds the MAC mode codes, the exception-flag and result-entry types, and the
// helper that decides which modes report FP exception flags.
package mac_pkg;

  localparam logic [2:0] MODE_FP16     = 3'b000;
  localparam logic [2:0] MODE_FP16_MIX = 3'b001;
  localparam logic [2:0] MODE_FP32     = 3'b010;
  localparam logic [2:0] MODE_INT4     = 3'b011;
  localparam logic [2:0] MODE_ADJ16    = 3'b100;
  localparam logic [2:0] MODE_INT4_MIX = 3'b101;
  localparam logic [2:0] MODE_INT8_MIX = 3'b110;
  localparam logic [2:0] MODE_ILLEGAL  = 3'b111;

  localparam int unsigned MAC_DATA_W    = 128;
  // Widest user tag a result entry can carry; narrower tags are zero-padded.
  localparam int unsigned MAC_TAG_MAX_W = 16;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } mac_flags_t;

  typedef struct packed {
    logic [MAC_DATA_W-1:0]    data;
    logic [MAC_TAG_MAX_W-1:0] tag;
    logic [2:0]               mode;
    mac_flags_t               flags;
    logic                     err;
  } mac_result_t;

  // Only the floating-point modes report exceptions; integer and adjacent-add
  // modes have their flags forced to zero.
  function automatic mac_flags_t mask_flags(input logic [2:0] mode, input mac_flags_t flags);
    return (mode inside {MODE_FP16, MODE_FP16_MIX, MODE_FP32}) ? flags : '0;
  endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous FIFO of mac_result_t entries.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push_i       write wdata_i this cycle
//   wdata_i      entry to write
//   pop_i        drop the head entry this cycle
//   rdata_o      head entry, read straight from registered storage
//   empty_o      no entries held
//   full_o       Depth entries held
//   occupancy_o  number of entries held
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  mac_result_t              wdata_i,
  input  logic                     pop_i,
  output mac_result_t              rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  mac_result_t      mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CntW'(Depth));
  assign occupancy_o = count_q;

  // Upstream credits must make these impossible.
  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
  assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/mac_result_collector.sv
// Collects MAC results MAC_LAT cycles after issue, buffers them and hands them
// to the tile writeback over a valid/ready port. Issue-side credits keep the
// non-stallable MAC from ever delivering a result without a free FIFO slot.
// Optional build macro: MAC_RESULT_BYPASS_EN (empty-FIFO capture is presented
// on out_* in the capture cycle instead of one cycle later).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   issue_valid_i/ready_o      issue handshake; ready means a credit is free
//   issue_mode_i, issue_tag_i  mode and user tag of the issued operation
//   mac_out_i, mac_*_i         MAC result and NV/OF/UF/NX flags at issue+MAC_LAT
//   out_valid_o/ready_i        result handshake toward writeback
//   out_data/tag/mode_o        result entry fields
//   out_flags_o, out_err_o     masked {NV,OF,UF,NX}, illegal-mode marker
//   sticky_flags_o, flags_clr_i  accumulated popped flags and their clear
//   occupancy_o                FIFO entries held
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [2:0]                issue_mode_i,
  input  logic [TAG_W-1:0]          issue_tag_i,
  input  logic [127:0]              mac_out_i,
  input  logic                      mac_nv_i,
  input  logic                      mac_of_i,
  input  logic                      mac_uf_i,
  input  logic                      mac_nx_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [127:0]              out_data_o,
  output logic [TAG_W-1:0]          out_tag_o,
  output logic [2:0]                out_mode_o,
  output logic [3:0]                out_flags_o,
  output logic                      out_err_o,
  output logic [3:0]                sticky_flags_o,
  input  logic                      flags_clr_i,
  output logic [$clog2(DEPTH):0]    occupancy_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  logic [MAC_LAT-1:0] vld_q;
  logic [2:0]         mode_q [MAC_LAT];
  logic [TAG_W-1:0]   tag_q  [MAC_LAT];
  logic [CntW-1:0]    inflight, occ;
  logic [3:0]         sticky_q;
  logic               accept, capture, bypass, pop, fifo_push, fifo_pop, fifo_empty;
  logic               fifo_full;
  mac_result_t        tail, fifo_head, head;

  // Delay line: only the valid bits need reset; payload follows them.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < MAC_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    mode_q[0] <= issue_mode_i;
    tag_q[0]  <= issue_tag_i;
    for (int i = 1; i < MAC_LAT; i++) begin
      mode_q[i] <= mode_q[i-1];
      tag_q[i]  <= tag_q[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAC_LAT; i++) inflight = inflight + CntW'(vld_q[i]);
  end

  // Every accepted operation holds a credit until its result is popped.
  assign issue_ready_o = (SumW'(inflight) + SumW'(occ)) < SumW'(DEPTH);
  assign accept        = issue_valid_i & issue_ready_o;
  assign capture       = vld_q[MAC_LAT-1];

  always_comb begin
    tail                 = '0;
    tail.data            = mac_out_i;
    tail.tag[TAG_W-1:0]  = tag_q[MAC_LAT-1];
    tail.mode            = mode_q[MAC_LAT-1];
    tail.flags           = mask_flags(mode_q[MAC_LAT-1],
                                      '{nv: mac_nv_i, of: mac_of_i, uf: mac_uf_i, nx: mac_nx_i});
    tail.err             = (mode_q[MAC_LAT-1] == MODE_ILLEGAL);
  end

`ifdef MAC_RESULT_BYPASS_EN
  assign bypass = capture & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = ~fifo_empty | bypass;
  assign pop         = out_valid_o & out_ready_i;
  assign fifo_pop    = pop & ~fifo_empty;
  // A bypassed entry consumed in its capture cycle never enters the FIFO.
  assign fifo_push   = capture & ~(bypass & out_ready_i);
  assign head        = bypass ? tail : fifo_head;

  mac_result_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .wdata_i     (tail),
    .pop_i       (fifo_pop),
    .rdata_o     (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .occupancy_o (occ)
  );

  // Zeroed while nothing is valid so idle/reset outputs read as zero.
  always_comb begin
    out_data_o  = '0;
    out_tag_o   = '0;
    out_mode_o  = '0;
    out_flags_o = '0;
    out_err_o   = 1'b0;
    if (out_valid_o) begin
      out_data_o  = head.data;
      out_tag_o   = head.tag[TAG_W-1:0];
      out_mode_o  = head.mode;
      out_flags_o = head.flags;
      out_err_o   = head.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (flags_clr_i ? 4'b0 : sticky_q) | (pop ? out_flags_o : 4'b0);
    end
  end

  assign sticky_flags_o = sticky_q;
  assign occupancy_o    = occ;

  if (TAG_W < MAC_TAG_MAX_W) begin : g_tag_pad
    logic unused_tag_hi;
    assign unused_tag_hi = ^fifo_head.tag[MAC_TAG_MAX_W-1:TAG_W];
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mac_result_collector.sv
module tb_mac_result_collector;

  localparam int MacLat = 2;
  localparam int Depth  = 4;
  localparam int TagW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [2:0]       issue_mode_i = '0;
  logic [TagW-1:0]  issue_tag_i = '0;
  logic [127:0]     mac_out_i = '0;
  logic             mac_nv_i = 1'b0, mac_of_i = 1'b0, mac_uf_i = 1'b0, mac_nx_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [127:0]     out_data_o;
  logic [TagW-1:0]  out_tag_o;
  logic [2:0]       out_mode_o;
  logic [3:0]       out_flags_o;
  logic             out_err_o;
  logic [3:0]       sticky_flags_o;
  logic             flags_clr_i = 1'b0;
  logic [2:0]       occupancy_o;

  mac_result_collector #(
    .MAC_LAT (MacLat),
    .DEPTH   (Depth),
    .TAG_W   (TagW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_mode_i   (issue_mode_i),
    .issue_tag_i    (issue_tag_i),
    .mac_out_i      (mac_out_i),
    .mac_nv_i       (mac_nv_i),
    .mac_of_i       (mac_of_i),
    .mac_uf_i       (mac_uf_i),
    .mac_nx_i       (mac_nx_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_tag_o      (out_tag_o),
    .out_mode_o     (out_mode_o),
    .out_flags_o    (out_flags_o),
    .out_err_o      (out_err_o),
    .sticky_flags_o (sticky_flags_o),
    .flags_clr_i    (flags_clr_i),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk = ~clk;

  // One operation as seen by the reference model.
  typedef struct {
    int              cap;
    logic [2:0]      mode;
    logic [TagW-1:0] tag;
    logic [127:0]    data;
    logic [3:0]      flags;
    logic            err;
  } op_t;

  op_t        pipe[$];   // accepted, result not yet delivered by the MAC
  op_t        exq[$];    // result delivered, not yet popped
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         dut_acc = 0;
  logic [3:0] sticky_m = '0;

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Called #1 after a rising edge; drives one cycle, checks at the falling
  // edge, then advances the model across the next rising edge.
  task automatic run_cycle(input logic iv, input logic [2:0] md, input logic [TagW-1:0] tg,
                           input logic ordy, input logic clr);
    logic [3:0] raw;
    op_t        e;
    int         occ;
    logic       ev, er, pop;
    issue_valid_i = iv;
    issue_mode_i  = md;
    issue_tag_i   = tg;
    out_ready_i   = ordy;
    flags_clr_i   = clr;
    mac_out_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
    raw           = 4'($urandom());
    {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i} = raw;
    if (pipe.size() > 0 && pipe[0].cap == cyc) begin
      e       = pipe.pop_front();
      e.data  = mac_out_i;
      e.flags = (e.mode <= 3'd2) ? raw : 4'b0;
      e.err   = (e.mode == 3'b111);
      exq.push_back(e);
    end
    @(negedge clk);
    if (iv && issue_ready_o) dut_acc++;
    er  = (pipe.size() + exq.size()) < Depth;
    occ = 0;
    foreach (exq[i]) if (exq[i].cap < cyc) occ++;
`ifdef MAC_RESULT_BYPASS_EN
    ev = exq.size() > 0;
`else
    ev = exq.size() > 0 && exq[0].cap < cyc;
`endif
    check_eq("issue_ready", 128'(issue_ready_o), 128'(er));
    check_eq("out_valid", 128'(out_valid_o), 128'(ev));
    check_eq("occupancy", 128'(occupancy_o), 128'(occ));
    check_eq("sticky", 128'(sticky_flags_o), 128'(sticky_m));
    if (ev) begin
      check_eq("data", out_data_o, exq[0].data);
      check_eq("tag", 128'(out_tag_o), 128'(exq[0].tag));
      check_eq("mode", 128'(out_mode_o), 128'(exq[0].mode));
      check_eq("flags", 128'(out_flags_o), 128'(exq[0].flags));
      check_eq("err", 128'(out_err_o), 128'(exq[0].err));
    end
    pop = ev && ordy;
    @(posedge clk);
    sticky_m = (clr ? 4'b0 : sticky_m) | (pop ? exq[0].flags : 4'b0);
    if (pop) void'(exq.pop_front());
    if (iv && er) begin
      e      = '{cap: cyc + MacLat, mode: md, tag: tg, data: '0, flags: '0, err: 1'b0};
      pipe.push_back(e);
    end
    cyc++;
    #1;
  endtask

  // Reset with an issue attempt and MAC garbage present, then check idle outputs.
  task automatic do_reset();
    rst           = 1'b1;
    issue_valid_i = 1'b1;
    out_ready_i   = 1'b0;
    flags_clr_i   = 1'b0;
    mac_out_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    #1;
    rst = 1'b0;
    pipe.delete();
    exq.delete();
    sticky_m = '0;
    cyc++;
    issue_valid_i = 1'b0;
    mac_out_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    check_eq("rst_valid", 128'(out_valid_o), 128'(0));
    check_eq("rst_data", out_data_o, 128'(0));
    check_eq("rst_tag", 128'(out_tag_o), 128'(0));
    check_eq("rst_flags", 128'({out_mode_o, out_flags_o, out_err_o}), 128'(0));
    check_eq("rst_sticky", 128'(sticky_flags_o), 128'(0));
    check_eq("rst_occupancy", 128'(occupancy_o), 128'(0));
    check_eq("rst_ready", 128'(issue_ready_o), 128'(1));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 3'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    do_reset();
    idle(3, 1'b1);

    // Single FP32, integer-mode and illegal-mode operations.
    run_cycle(1'b1, 3'b010, 4'd3, 1'b1, 1'b0);
    idle(4, 1'b1);
    run_cycle(1'b1, 3'b101, 4'd5, 1'b1, 1'b0);
    idle(4, 1'b1);
    run_cycle(1'b1, 3'b111, 4'd7, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Fill with consumer stalled: exactly Depth accepted, then in-order drain.
    dut_acc = 0;
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 3'($urandom_range(7, 0)), 4'(i), 1'b0, 1'b0);
    check_eq("fill_accepts", 128'(dut_acc), 128'(Depth));
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Streaming with the consumer always ready; pointers wrap several times.
    for (int i = 0; i < 16; i++) run_cycle(1'b1, 3'($urandom_range(7, 0)), 4'(i), 1'b1, 1'b0);
    idle(MacLat + 2, 1'b1);

    // Reset with two results in flight and two buffered.
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 3'b000, 4'(i), 1'b0, 1'b0);
    do_reset();
    idle(5, 1'b1);

    // Clear asserted in the same cycle as pops of FP16 results.
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 3'b000, 4'(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 3'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(149, 0) == 0) do_reset();
      else run_cycle(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 4'($urandom()),
                     1'($urandom_range(2, 0) != 0), 1'($urandom_range(9, 0) == 0));
    end
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
